// File: rtl/decode_ctrl_stage.sv
// RV32I decode stage: registers the execute control bundle behind a valid/ready
// handshake and holds off issue for a fixed number of cycles after memory ops.
module decode_ctrl_stage #(
  parameter int XLEN    = 32,
  parameter int MEM_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic            branchValid,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            branchEn,
  output logic            jumpEn,
  output logic [2:0]      immExtCtrl,
  output logic [XLEN-1:0] imm_data,
  output logic [2:0]      branchCompareOp,
  output logic            aluS1Sel,
  output logic            aluS2Sel,
  output logic [3:0]      aluOp,
  output logic [3:0]      memControl,
  output logic            memUnsigned,
  output logic            regWriteEn,
  output logic            regWriteBackDataSel,
  output logic            linkRegWriteEn,
  output logic            illegal
);

  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6F, OP_JALR = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63, OP_LOAD = 7'h03, OP_STORE = 7'h23;
  localparam logic [6:0] OP_IMM = 7'h13, OP_REG = 7'h33, OP_FENCE = 7'h0F, OP_SYSTEM = 7'h73;
  localparam logic [2:0] IMM_NONE = 3'd0, IMM_I = 3'd1, IMM_S = 3'd2, IMM_B = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4, IMM_J = 3'd5;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_PASSB = 4'd10;
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_VALID, S_MEM_WAIT} state_t;

  function automatic logic signed [XLEN-1:0] imm_ext(input logic [2:0] sel, input logic [31:0] w);
    logic signed [31:0] v;
    case (sel)
      IMM_I:   v = {{20{w[31]}}, w[31:20]};
      IMM_S:   v = {{20{w[31]}}, w[31:25], w[11:7]};
      IMM_B:   v = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      IMM_U:   v = {w[31:12], 12'b0};
      IMM_J:   v = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: v = '0;
    endcase
    return XLEN'(v);
  endfunction

  function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_sel = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_sel = 4'd2;
      3'b010:  alu_sel = 4'd3;
      3'b011:  alu_sel = 4'd4;
      3'b100:  alu_sel = 4'd5;
      3'b101:  alu_sel = alt ? 4'd7 : 4'd6;
      3'b110:  alu_sel = 4'd8;
      default: alu_sel = 4'd9;
    endcase
  endfunction

  state_t                 state, state_nx;
  logic [CW-1:0]          wait_cnt;
  logic                   rst_done, is_branch_p0, load, mem_op;
  logic [6:0]             opcode, f7;
  logic [2:0]             f3;
  logic                   jump_d, s1_d, s2_d, memu_d, rwe_d, wbs_d, link_d, ill_d, br_d;
  logic [2:0]             ext_d, bco_d;
  logic [3:0]             alu_d, mem_d;
  logic signed [XLEN-1:0] imm_d;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];
  assign mem_op = memControl[3:2] != 2'b00;
  assign load   = in_valid & in_ready;

  // Decode: illegal encodings leave every control at zero except illegal.
  always_comb begin
    jump_d = 1'b0; ext_d = IMM_NONE; bco_d = 3'd0; s1_d = 1'b0; s2_d = 1'b0;
    alu_d = ALU_ADD; mem_d = 4'd0; memu_d = 1'b0; rwe_d = 1'b0; wbs_d = 1'b0;
    link_d = 1'b0; ill_d = 1'b0; br_d = 1'b0;
    case (opcode)
      OP_LUI:   begin ext_d = IMM_U; s2_d = 1'b1; alu_d = ALU_PASSB; rwe_d = 1'b1; end
      OP_AUIPC: begin ext_d = IMM_U; s2_d = 1'b1; rwe_d = 1'b1; end
      OP_JAL:   begin ext_d = IMM_J; s2_d = 1'b1; jump_d = 1'b1; link_d = 1'b1; rwe_d = 1'b1; end
      OP_JALR:
        if (f3 != 3'b000) ill_d = 1'b1;
        else begin
          ext_d = IMM_I; s1_d = 1'b1; s2_d = 1'b1; jump_d = 1'b1; link_d = 1'b1; rwe_d = 1'b1;
        end
      OP_BRANCH:
        if (f3[2:1] == 2'b01) ill_d = 1'b1;
        else begin ext_d = IMM_B; s1_d = 1'b1; alu_d = ALU_SUB; bco_d = f3; br_d = 1'b1; end
      OP_LOAD:
        if (f3 == 3'b011 || f3[2:1] == 2'b11) ill_d = 1'b1;
        else begin
          ext_d = IMM_I; s1_d = 1'b1; s2_d = 1'b1; mem_d = {2'b01, f3[1:0]};
          memu_d = f3[2]; rwe_d = 1'b1; wbs_d = 1'b1;
        end
      OP_STORE:
        if (f3[2] || f3[1:0] == 2'b11) ill_d = 1'b1;
        else begin ext_d = IMM_S; s1_d = 1'b1; s2_d = 1'b1; mem_d = {2'b10, f3[1:0]}; end
      OP_IMM:
        if ((f3 == 3'b001 && f7 != 7'h00) || (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20))
          ill_d = 1'b1;
        else begin
          ext_d = IMM_I; s1_d = 1'b1; s2_d = 1'b1; rwe_d = 1'b1;
          alu_d = alu_sel(f3, f3 == 3'b101 && f7[5]);
        end
      OP_REG:
        if (f7 != 7'h00 && !(f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))) ill_d = 1'b1;
        else begin s1_d = 1'b1; rwe_d = 1'b1; alu_d = alu_sel(f3, f7[5]); end
      OP_FENCE, OP_SYSTEM: ;
      default:  ill_d = 1'b1;
    endcase
    imm_d = imm_ext(ext_d, inst);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      rst_done <= 1'b0;
    end else begin
      state    <= state_nx;
      rst_done <= 1'b1;
      if (state == S_VALID && state_nx == S_MEM_WAIT) wait_cnt <= CW'(MEM_LAT - 1);
      else if (state == S_MEM_WAIT && wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (in_valid && rst_done) state_nx = S_VALID;
      S_VALID:
        if (out_ready) begin
          if (mem_op && MEM_LAT > 0)  state_nx = S_MEM_WAIT;
          else if (!mem_op && in_valid) state_nx = S_VALID;
          else                          state_nx = S_IDLE;
        end
      S_MEM_WAIT: if (wait_cnt == '0) state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE:  in_ready = rst_done;
      S_VALID: begin out_valid = 1'b1; in_ready = out_ready & ~mem_op; end
      default: ;
    endcase
  end

  // Bundle register: loaded on every accepted instruction, otherwise held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      jumpEn <= 1'b0; immExtCtrl <= '0; imm_data <= '0; branchCompareOp <= '0;
      aluS1Sel <= 1'b0; aluS2Sel <= 1'b0; aluOp <= '0; memControl <= '0;
      memUnsigned <= 1'b0; regWriteEn <= 1'b0; regWriteBackDataSel <= 1'b0;
      linkRegWriteEn <= 1'b0; illegal <= 1'b0; is_branch_p0 <= 1'b0;
    end else if (load) begin
      jumpEn <= jump_d; immExtCtrl <= ext_d; imm_data <= imm_d; branchCompareOp <= bco_d;
      aluS1Sel <= s1_d; aluS2Sel <= s2_d; aluOp <= alu_d; memControl <= mem_d;
      memUnsigned <= memu_d; regWriteEn <= rwe_d; regWriteBackDataSel <= wbs_d;
      linkRegWriteEn <= link_d; illegal <= ill_d; is_branch_p0 <= br_d;
    end
  end

  assign branchEn = out_valid & is_branch_p0 & branchValid;

endmodule
